vga_sync_rx: RTL and testbench
==============================

Name: vga_sync_rx

Overview:
- Receive side of the 640x480@60 VGA/HDMI parallel video interface: consumes hsync, vsync and 16-bit RGB565, the same signals the timing controller drives.
- Recovers the pixel coordinates, the data-enable and a frame-start strobe.
- Measures line and frame totals and declares lock once the timing matches nominal.
- Used for loopback checking of the colour-bar path and as the front end of future capture logic.

Parameters:
- H_SYNC, 96, hsync asserted width in clocks
- H_BACK, 48, horizontal back porch in clocks
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, nominal clocks per line
- V_SYNC, 2, vsync asserted width in lines
- V_BACK, 33, vertical back porch in lines
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, nominal lines per frame
- LOCK_FRAMES, 2, consecutive matching frames required to lock
- SYNC_POL, 1, 1 = sync asserted high, 0 = asserted low

Ports:
- vga_clk  in  1  pixel clock (25 MHz)
- reset  in  1  asynchronous, active-high reset
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- rgb_in  in  16  RGB565 pixel data
- de  out  1  active-pixel qualifier, aligned with pix_data
- pix_x  out  10  active column 0..639; 0 when de=0
- pix_y  out  10  active row 0..479; 0 when de=0
- pix_data  out  16  pixel, valid when de=1; 0 when de=0
- frame_start  out  1  one-cycle pulse with the pixel (0,0)
- locked  out  1  timing lock indicator
- h_total_meas  out  12  last measured clocks per line
- v_total_meas  out  11  last measured lines per frame
- frame_sum  out  16  per-frame pixel checksum (optional feature)

Behaviour:
- Reset: all outputs and internal registers are 0, and the FSM enters UNLOCKED. Reset is asynchronous, so it may assert mid-frame; after release the block re-acquires lock from scratch.
- Input stage:
  - hsync, vsync and rgb_in are registered once.
  - Sync is normalised by SYNC_POL, so hs and vs mean "asserted".
  - A second register of hs and vs provides assertion-edge detection: hs_edge and vs_edge.
- Horizontal counter cnt_h (12 bits):
  - On hs_edge it loads 0; the first asserted hsync sample is column 0.
  - Otherwise it increments, saturating at 4095.
  - On hs_edge, h_total_meas <= previous cnt_h + 1.
- Line counter cnt_v (11 bits):
  - A vs_pending flag is set by vs_edge and cleared on hs_edge.
  - On hs_edge: if vs_pending or vs_edge (same cycle) then cnt_v <= 0 and v_total_meas <= previous cnt_v + 1; else cnt_v increments, saturating at 2047.
- Active window:
  - Horizontal: H_SYNC+H_BACK <= cnt_h < H_SYNC+H_BACK+H_ACTIVE.
  - Vertical: V_SYNC+V_BACK <= cnt_v < V_SYNC+V_BACK+V_ACTIVE.
- Output register stage:
  - de = window && locked.
  - pix_x = cnt_h-(H_SYNC+H_BACK); pix_y = cnt_v-(V_SYNC+V_BACK).
  - pix_data = registered rgb_in.
  - Latency: 2 clocks from the rgb_in sample to pix_data.
- frame_start is 1 exactly when de=1 with pix_x=0 and pix_y=0.
- Lock FSM, evaluated at each frame boundary (hs_edge with vertical reset):
  - UNLOCKED: if h_total_meas==H_TOTAL and the new v_total_meas==V_TOTAL, go to CHECK with match count 1; else stay.
  - CHECK: on a match, increment the count and go to LOCKED when it reaches LOCK_FRAMES; on a mismatch, go to UNLOCKED.
  - LOCKED: locked=1. Any hs_edge with h_total_meas!=H_TOTAL, or any frame mismatch, goes to UNLOCKED in the same cycle.
  - Timeout: cnt_h reaching 4095 (hsync lost) forces UNLOCKED; cnt_v reaching 2047 does the same.
- The first frame after reset is partial, so it never counts as a match.

Optional Feature:
- Macro VGA_RX_CHECKSUM_EN.
- When defined:
  - A 16-bit accumulator adds pix_data (mod 2^16) on every de cycle.
  - It clears on frame_start, which is added as the first term.
  - At each frame boundary, frame_sum latches the accumulator.
  - Reset value 0.
- When undefined: frame_sum is constant 0 and no accumulator is built.

Test Plan:
- Nominal 800x525 timing with sync high and constant rgb 16'hF800: locked rises at the end of the 2nd full frame; afterwards 640 de cycles per line and 480 lines per frame, pix_data=16'hF800, h_total_meas=800, v_total_meas=525.
- Coordinate ramp with rgb_in = {row[5:0], col[9:0]}: after lock, pix_data equals {pix_y[5:0], pix_x}, arriving 2 clocks after input; frame_start occurs exactly once per frame.
- One line of 801 clocks while locked: locked drops at that hsync edge, h_total_meas=801, de=0 thereafter; lock is re-acquired after 2 clean frames.
- hsync held deasserted 5000 clocks while locked: locked=0 when cnt_h reaches 4095, and no de is produced.
- Reset asserted mid-line at an arbitrary clock: all outputs are 0 in the same clock, asynchronously; after release, lock returns only after a partial frame plus 2 full frames.
- With VGA_RX_CHECKSUM_EN and constant rgb 16'h0001: frame_sum = 307200 mod 65536 = 45056 (16'hB000). Without the macro, frame_sum stays 0.

Source files
------------

// File: rtl/vga_sync_rx.sv
// Video receive front end: recovers pixel coordinates, de, frame_start and timing lock from hsync/vsync/RGB565.
// Latency: 2 clocks from the rgb_in sample to pix_data/de/pix_x/pix_y.
// Backpressure: none; free-running pixel stream. Define VGA_RX_CHECKSUM_EN to build the per-frame pixel checksum.
module vga_sync_rx #(
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2,
  parameter int SYNC_POL    = 1
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] rgb_in,
  output logic        de,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        frame_start,
  output logic        locked,
  output logic [11:0] h_total_meas,
  output logic [10:0] v_total_meas,
  output logic [15:0] frame_sum
);

  localparam logic [11:0] H_START   = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_END     = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  H_START10 = 10'(H_SYNC + H_BACK);
  localparam logic [10:0] V_START   = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_END     = 11'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0]  V_START10 = 10'(V_SYNC + V_BACK);
  localparam logic [11:0] H_NOM     = 12'(H_TOTAL);
  localparam logic [10:0] V_NOM     = 11'(V_TOTAL);
  localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECK    = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // Input stage and edge-detect registers
  logic        hs_q, vs_q, hs_dly_q, vs_dly_q;
  logic [15:0] rgb_q, rgb_dly_q;
  // Timing counters and measurements
  logic [11:0] cnt_h_q, h_meas_q;
  logic [10:0] cnt_v_q, v_meas_q;
  logic        vs_pend_q;
  // Lock FSM
  state_t      state_q, state_d;
  logic [3:0]  match_q, match_d;
  logic        seen_q, seen_d;
  logic        line_bad_q, line_bad_d;
  // Output stage
  logic        de_q, fs_q;
  logic [9:0]  pix_x_q, pix_y_q;
  logic [15:0] pix_data_q;

  logic        hs_norm, vs_norm, hs_edge, vs_edge, frame_edge;
  logic [11:0] h_meas_new;
  logic [10:0] v_meas_new;
  logic        h_ok, v_ok, frame_match, timeout, act;

  assign hs_norm     = (SYNC_POL != 0) ? hsync : ~hsync;
  assign vs_norm     = (SYNC_POL != 0) ? vsync : ~vsync;
  assign hs_edge     = hs_q & ~hs_dly_q;
  assign vs_edge     = vs_q & ~vs_dly_q;
  // A vsync edge may land on the same clock as the hsync edge that closes the frame.
  assign frame_edge  = hs_edge & (vs_pend_q | vs_edge);
  assign h_meas_new  = cnt_h_q + 12'd1;
  assign v_meas_new  = cnt_v_q + 11'd1;
  assign h_ok        = (h_meas_new == H_NOM);
  assign v_ok        = (v_meas_new == V_NOM);
  // A frame only matches if it followed a previous boundary (not the partial
  // frame after reset) and every line in it measured nominal.
  assign frame_match = seen_q & h_ok & v_ok & ~line_bad_q;
  assign timeout     = (cnt_h_q == 12'hFFF) | (cnt_v_q == 11'h7FF);
  assign act         = (cnt_h_q >= H_START) && (cnt_h_q < H_END) &&
                       (cnt_v_q >= V_START) && (cnt_v_q < V_END) &&
                       (state_q == ST_LOCKED);

  // Register raw inputs, normalise sync polarity, keep a delayed copy for edge detection
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      hs_dly_q  <= 1'b0;
      vs_dly_q  <= 1'b0;
      rgb_q     <= 16'd0;
      rgb_dly_q <= 16'd0;
    end else begin
      hs_q      <= hs_norm;
      vs_q      <= vs_norm;
      hs_dly_q  <= hs_q;
      vs_dly_q  <= vs_q;
      rgb_q     <= rgb_in;
      rgb_dly_q <= rgb_q;
    end
  end

  // Column/line counters with saturation, and line/frame total measurement
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      cnt_h_q   <= 12'd0;
      cnt_v_q   <= 11'd0;
      h_meas_q  <= 12'd0;
      v_meas_q  <= 11'd0;
      vs_pend_q <= 1'b0;
    end else begin
      if (hs_edge) begin
        cnt_h_q  <= 12'd0;
        h_meas_q <= h_meas_new;
      end else if (cnt_h_q != 12'hFFF) begin
        cnt_h_q <= cnt_h_q + 12'd1;
      end
      if (hs_edge) begin
        vs_pend_q <= 1'b0;
      end else if (vs_edge) begin
        vs_pend_q <= 1'b1;
      end
      if (frame_edge) begin
        cnt_v_q  <= 11'd0;
        v_meas_q <= v_meas_new;
      end else if (hs_edge && (cnt_v_q != 11'h7FF)) begin
        cnt_v_q <= cnt_v_q + 11'd1;
      end
    end
  end

  // Lock FSM state register
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_UNLOCKED;
      match_q    <= 4'd0;
      seen_q     <= 1'b0;
      line_bad_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      seen_q     <= seen_d;
      line_bad_q <= line_bad_d;
    end
  end

  // Lock FSM next state: frame evaluation at each boundary, immediate drop on bad line or timeout
  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    seen_d     = seen_q;
    line_bad_d = line_bad_q;
    if (frame_edge) begin
      seen_d     = 1'b1;
      line_bad_d = 1'b0;
    end else if (hs_edge && !h_ok) begin
      line_bad_d = 1'b1;
    end
    case (state_q)
      ST_UNLOCKED: begin
        if (frame_edge && frame_match) begin
          match_d = 4'd1;
          state_d = (LOCK_N <= 4'd1) ? ST_LOCKED : ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (frame_edge) begin
          if (frame_match) begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 >= LOCK_N) begin
              state_d = ST_LOCKED;
            end
          end else begin
            match_d = 4'd0;
            state_d = ST_UNLOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if ((hs_edge && !h_ok) || (frame_edge && !frame_match)) begin
          match_d = 4'd0;
          state_d = ST_UNLOCKED;
        end
      end
      default: begin
        match_d = 4'd0;
        state_d = ST_UNLOCKED;
      end
    endcase
    if (timeout) begin
      match_d = 4'd0;
      state_d = ST_UNLOCKED;
    end
  end

  // Output register: coordinates and data are forced to zero outside the locked active window
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      pix_x_q    <= 10'd0;
      pix_y_q    <= 10'd0;
      pix_data_q <= 16'd0;
    end else begin
      de_q       <= act;
      fs_q       <= act && (cnt_h_q == H_START) && (cnt_v_q == V_START);
      pix_x_q    <= act ? (cnt_h_q[9:0] - H_START10) : 10'd0;
      pix_y_q    <= act ? (cnt_v_q[9:0] - V_START10) : 10'd0;
      pix_data_q <= act ? rgb_dly_q : 16'd0;
    end
  end

  assign de           = de_q;
  assign frame_start  = fs_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign pix_data     = pix_data_q;
  assign locked       = (state_q == ST_LOCKED);
  assign h_total_meas = h_meas_q;
  assign v_total_meas = v_meas_q;

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] acc_q, sum_q;

  // Per-frame modulo-2^16 pixel sum, restarted by frame_start and latched at the frame boundary
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      acc_q <= 16'd0;
      sum_q <= 16'd0;
    end else begin
      if (de_q) begin
        acc_q <= fs_q ? pix_data_q : (acc_q + pix_data_q);
      end
      if (frame_edge) begin
        sum_q <= acc_q;
      end
    end
  end

  assign frame_sum = sum_q;
`else
  assign frame_sum = 16'd0;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx on a reduced 20x10 raster (4/3/8 horizontal, 2/2/4 vertical).
// Inputs driven on the falling edge; outputs compared three falling edges after the matching drive.
// No flow control on this interface.
module tb_vga_sync_rx;

  localparam int HS = 4, HB = 3, HA = 8, HT = 20;
  localparam int VS = 2, VB = 2, VA = 4, VT = 10;
  localparam int XS = HS + HB;
  localparam int YS = VS + VB;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic        hsync, vsync;
  logic [15:0] rgb_in;
  logic        de, frame_start, locked;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] pix_data, frame_sum;
  logic [11:0] h_total_meas;
  logic [10:0] v_total_meas;

  vga_sync_rx #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .LOCK_FRAMES(2), .SYNC_POL(1)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb_in(rgb_in),
    .de(de), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .locked(locked),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas), .frame_sum(frame_sum)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;

  // raster generator state (position of the next drive)
  int          g_line = 0;
  int          g_col  = 0;
  int          long_line = -1;
  bit          hs_kill = 1'b0;
  int          rgb_mode = 0;
  logic [15:0] rgb_const = 16'd0;

  // last three drives; index 2 is the one whose result is visible now
  bit          h_act [3];
  logic [9:0]  h_x   [3];
  logic [9:0]  h_y   [3];
  logic [15:0] h_rgb [3];

  bit mon_en   = 1'b0;
  bit exp_lock = 1'b0;
  int mism = 0, de_cnt = 0, fs_cnt = 0;

  logic [31:0] exp_sum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    bit          ea, efs, act;
    logic [9:0]  ex, ey, cx, ry;
    logic [15:0] ed;
    int          len;
    @(negedge vga_clk);
    if (de === 1'b1) de_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
    ea  = exp_lock && h_act[2];
    ex  = ea ? h_x[2] : 10'd0;
    ey  = ea ? h_y[2] : 10'd0;
    ed  = ea ? h_rgb[2] : 16'd0;
    efs = ea && (h_x[2] == 10'd0) && (h_y[2] == 10'd0);
    if (mon_en && ((de !== ea) || (pix_x !== ex) || (pix_y !== ey) ||
                   (pix_data !== ed) || (frame_start !== efs))) mism++;
    act = (g_line >= YS) && (g_line < YS + VA) && (g_col >= XS) && (g_col < XS + HA);
    cx  = 10'(g_col - XS);
    ry  = 10'(g_line - YS);
    hsync  = !hs_kill && (g_col < HS);
    vsync  = (g_line < VS);
    rgb_in = (rgb_mode == 1) ? (act ? {ry[5:0], cx} : 16'hDEAD) : rgb_const;
    for (int i = 2; i > 0; i--) begin
      h_act[i] = h_act[i-1];
      h_x[i]   = h_x[i-1];
      h_y[i]   = h_y[i-1];
      h_rgb[i] = h_rgb[i-1];
    end
    h_act[0] = act;
    h_x[0]   = cx;
    h_y[0]   = ry;
    h_rgb[0] = rgb_in;
    len = (g_line == long_line) ? HT + 1 : HT;
    g_col++;
    if (g_col >= len) begin
      g_col  = 0;
      g_line = (g_line + 1) % VT;
    end
  endtask

  task automatic run_until(input int l, input int c);
    int n = 0;
    while (!(g_line == l && g_col == c) && n < 5000) begin
      step();
      n++;
    end
  endtask

  task automatic run_frames(input int k);
    repeat (k) begin
      step();
      run_until(0, 0);
    end
  endtask

  task automatic clear_mon();
    mism = 0;
    de_cnt = 0;
    fs_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      h_act[i] = 1'b0; h_x[i] = 10'd0; h_y[i] = 10'd0; h_rgb[i] = 16'd0;
    end
    reset = 1'b1; hsync = 1'b0; vsync = 1'b0; rgb_in = 16'd0;
    repeat (3) @(negedge vga_clk);
    check("rst_de",     32'(de),           32'd0);
    check("rst_pix_x",  32'(pix_x),        32'd0);
    check("rst_pix_y",  32'(pix_y),        32'd0);
    check("rst_data",   32'(pix_data),     32'd0);
    check("rst_fs",     32'(frame_start),  32'd0);
    check("rst_locked", 32'(locked),       32'd0);
    check("rst_hmeas",  32'(h_total_meas), 32'd0);
    check("rst_vmeas",  32'(v_total_meas), 32'd0);
    check("rst_fsum",   32'(frame_sum),    32'd0);
    reset = 1'b0;

    // nominal timing, constant red: lock at the end of the 2nd full frame
    rgb_const = 16'hF800;
    run_frames(2);
    check("nom_hmeas",       32'(h_total_meas), 32'd20);
    check("nom_vmeas",       32'(v_total_meas), 32'd10);
    step(); step();
    check("nom_lock_before", 32'(locked), 32'd0);
    step();
    check("nom_lock_rise",   32'(locked), 32'd1);

    mon_en = 1'b1; exp_lock = 1'b1; clear_mon();
    run_until(0, 0);
    run_frames(1);
    step(); step(); step();
    check("nom_mism",   32'(mism),   32'd0);
    check("nom_de_cnt", 32'(de_cnt), 32'd64);
    check("nom_fs_cnt", 32'(fs_cnt), 32'd2);
    check("nom_locked", 32'(locked), 32'd1);
    check("nom_hmeas2", 32'(h_total_meas), 32'd20);
    check("nom_vmeas2", 32'(v_total_meas), 32'd10);

    // coordinate ramp
    rgb_mode = 1; clear_mon();
    run_until(0, 0);
    run_frames(1);
    check("ramp_mism",   32'(mism),   32'd0);
    check("ramp_de_cnt", 32'(de_cnt), 32'd64);
    check("ramp_fs_cnt", 32'(fs_cnt), 32'd2);

    // constant 1: checksum over 32 active pixels
    rgb_mode = 0; rgb_const = 16'h0001; clear_mon();
    run_frames(1);
    step(); step(); step();
`ifdef VGA_RX_CHECKSUM_EN
    exp_sum = 32'h0020;
`else
    exp_sum = 32'h0000;
`endif
    check("ones_mism", 32'(mism),      32'd0);
    check("frame_sum", 32'(frame_sum), exp_sum);

    // one 21-clock line while locked
    long_line = 2;
    run_until(3, 0);
    long_line = -1;
    step(); step();
    check("long_lock_before", 32'(locked),       32'd1);
    check("long_hmeas_before", 32'(h_total_meas), 32'd20);
    step();
    check("long_lock_drop",   32'(locked),       32'd0);
    check("long_hmeas",       32'(h_total_meas), 32'd21);
    exp_lock = 1'b0; clear_mon();
    run_until(0, 0);
    check("long_no_de",  32'(de_cnt), 32'd0);
    check("long_mism",   32'(mism),   32'd0);
    run_frames(1);
    step(); step(); step();
    check("relock_after_1", 32'(locked), 32'd0);
    run_until(0, 0);
    step(); step();
    check("relock_before", 32'(locked), 32'd0);
    step();
    check("relock_rise",   32'(locked), 32'd1);
    exp_lock = 1'b1;

    // hsync lost for 5000 clocks while locked
    run_until(0, 0);
    clear_mon(); exp_lock = 1'b0; hs_kill = 1'b1;
    repeat (3000) step();
    check("hsloss_still_locked", 32'(locked), 32'd1);
    repeat (2000) step();
    check("hsloss_unlocked", 32'(locked), 32'd0);
    check("hsloss_no_de",    32'(de_cnt), 32'd0);
    check("hsloss_mism",     32'(mism),   32'd0);
    hs_kill = 1'b0;

    // re-lock, then asynchronous reset in the middle of an active line
    mon_en = 1'b0;
    run_frames(3);
    check("pre_rst_locked", 32'(locked), 32'd1);
    rgb_mode = 1;
    run_until(5, 13);
    check("pre_rst_de",    32'(de),       32'd1);
    check("pre_rst_x",     32'(pix_x),    32'd2);
    check("pre_rst_y",     32'(pix_y),    32'd1);
    check("pre_rst_data",  32'(pix_data), 32'h0402);
    #2 reset = 1'b1;
    #1;
    check("arst_de",     32'(de),           32'd0);
    check("arst_pix_x",  32'(pix_x),        32'd0);
    check("arst_pix_y",  32'(pix_y),        32'd0);
    check("arst_data",   32'(pix_data),     32'd0);
    check("arst_fs",     32'(frame_start),  32'd0);
    check("arst_locked", 32'(locked),       32'd0);
    check("arst_hmeas",  32'(h_total_meas), 32'd0);
    check("arst_vmeas",  32'(v_total_meas), 32'd0);
    check("arst_fsum",   32'(frame_sum),    32'd0);
    repeat (4) step();
    reset = 1'b0;
    run_until(0, 0);
    step(); step(); step();
    check("partial_vmeas", 32'(v_total_meas), 32'd5);
    check("partial_lock",  32'(locked),       32'd0);
    run_frames(2);
    step(); step();
    check("rst_relock_before", 32'(locked), 32'd0);
    step();
    check("rst_relock_rise",   32'(locked), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
